// File: rtl/hazard_ctrl_bp_pkg.sv
// Shared constants and helpers for the hazard/branch-prediction control unit.
package hazard_ctrl_bp_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam int BP_STATIC_NT = 0;
    localparam int BP_BIMODAL   = 1;
    localparam int BP_BTFN      = 2;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    typedef enum logic {
        LU_IDLE  = 1'b0,
        LU_STALL = 1'b1
    } lu_state_e;

    // Saturating 2-bit counter step towards the observed outcome.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/hazard_ctrl_bp_bht_2bit.sv
// Branch history table of 2-bit saturating counters: one async read port, one clocked update port.
module bht_2bit
    import hazard_ctrl_bp_pkg::*;
#(
    parameter int BHT_IDX = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BHT_IDX-1:0] rd_idx_i,
    output logic               rd_taken_o,
    input  logic               wr_en_i,
    input  logic [BHT_IDX-1:0] wr_idx_i,
    input  logic               wr_taken_i
);

    localparam int ENTRIES = 1 << BHT_IDX;

    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] wr_ctr_d;

    // Next value of the entry being trained.
    always_comb begin
        wr_ctr_d = ctr_next(ctr_q[wr_idx_i], wr_taken_i);
    end

    // Counter array; all entries start weakly not-taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= wr_ctr_d;
        end
    end

    // Reads see the pre-update value when the same entry is written this cycle.
    assign rd_taken_o = ctr_q[rd_idx_i][1];

endmodule

// File: rtl/hazard_ctrl_bp.sv
// Hazard/control unit for the 5-stage RV32I pipeline: load-use stalls, ID-stage
// branch prediction, EX-stage resolution with BHT training, and statistics.
module hazard_ctrl_bp
    import hazard_ctrl_bp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int BHT_IDX  = 6,
    parameter int BP_MODE  = 1,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [6:0]      id_opcode_i,
    input  logic [4:0]      id_rs1_addr_i,
    input  logic [4:0]      id_rs2_addr_i,
    input  logic            id_rs1_used_i,
    input  logic            id_rs2_used_i,
    input  logic [XLEN-1:0] id_target_i,
    input  logic            ex_valid_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [4:0]      ex_rd_addr_i,
    input  logic            ex_mem_read_i,
    input  logic            ex_is_branch_i,
    input  logic            ex_is_jalr_i,
    input  logic            ex_pred_taken_i,
    input  logic            ex_taken_i,
    input  logic [XLEN-1:0] ex_target_i,
    output logic            pc_write_en_o,
    output logic            if_id_write_en_o,
    output logic            if_id_flush_o,
    output logic            id_ex_flush_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            id_pred_taken_o,
    output logic            load_use_hazard_o,
    output logic [CNT_W-1:0] stat_branch_o,
    output logic [CNT_W-1:0] stat_mispred_o,
    output logic [CNT_W-1:0] stat_stall_o
);

    localparam int LC_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) + 1 : 1;
    localparam logic [LC_W-1:0]  LC_ZERO = {LC_W{1'b0}};
    localparam logic [LC_W-1:0]  LC_ONE  = LC_W'(1);
    localparam logic [LC_W-1:0]  LC_INIT = LC_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0]  PC_ZERO = {XLEN{1'b0}};

    lu_state_e       state_q, state_d;
    logic [LC_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0] stat_branch_q, stat_mispred_q, stat_stall_q;

    logic            hazard_s;
    logic            stall_s;
    logic            ex_mispred_s;
    logic            ex_jalr_s;
    logic            ex_redirect_s;
    logic [XLEN-1:0] ex_redirect_pc_s;
    logic            bht_taken_s;
    logic            id_pred_s;

    bht_2bit #(
        .BHT_IDX(BHT_IDX)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_i  (id_pc_i[BHT_IDX+1:2]),
        .rd_taken_o(bht_taken_s),
        .wr_en_i   (ex_valid_i & ex_is_branch_i),
        .wr_idx_i  (ex_pc_i[BHT_IDX+1:2]),
        .wr_taken_i(ex_taken_i)
    );

    // Hazard detection and EX-stage resolution.
    always_comb begin
        hazard_s = ex_valid_i & ex_mem_read_i & id_valid_i & (ex_rd_addr_i != 5'd0) &
                   ((id_rs1_used_i & (ex_rd_addr_i == id_rs1_addr_i)) |
                    (id_rs2_used_i & (ex_rd_addr_i == id_rs2_addr_i)));
        ex_mispred_s  = ex_valid_i & ex_is_branch_i & (ex_taken_i != ex_pred_taken_i);
        ex_jalr_s     = ex_valid_i & ex_is_jalr_i;
        ex_redirect_s = ex_mispred_s | ex_jalr_s;
        if (ex_jalr_s | ex_taken_i) begin
            ex_redirect_pc_s = ex_target_i;
        end else begin
            ex_redirect_pc_s = ex_pc_i + PC_STEP;
        end
    end

    // ID-stage prediction.
    always_comb begin
        id_pred_s = 1'b0;
        case (id_opcode_i)
            OPC_JAL: id_pred_s = 1'b1;
            OPC_BRANCH: begin
                case (BP_MODE)
                    BP_BIMODAL: id_pred_s = bht_taken_s;
                    BP_BTFN:    id_pred_s = (id_target_i < id_pc_i);
                    default:    id_pred_s = 1'b0;
                endcase
            end
            default: id_pred_s = 1'b0;
        endcase
    end

    // Load-use FSM next state; an EX redirect squashes the stall outright.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        stall_s   = 1'b0;
        if (ex_redirect_s) begin
            state_d   = LU_IDLE;
            lat_cnt_d = LC_ZERO;
        end else begin
            case (state_q)
                LU_IDLE: begin
                    if (hazard_s) begin
                        stall_s   = 1'b1;
                        lat_cnt_d = LC_INIT;
                        if (LC_INIT != LC_ZERO) begin
                            state_d = LU_STALL;
                        end else begin
                            state_d = LU_IDLE;
                        end
                    end else begin
                        state_d = LU_IDLE;
                    end
                end
                LU_STALL: begin
                    stall_s = 1'b1;
                    if (lat_cnt_q <= LC_ONE) begin
                        state_d   = LU_IDLE;
                        lat_cnt_d = LC_ZERO;
                    end else begin
                        lat_cnt_d = lat_cnt_q - LC_ONE;
                    end
                end
                default: begin
                    state_d   = LU_IDLE;
                    lat_cnt_d = LC_ZERO;
                end
            endcase
        end
    end

    // Load-use FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LU_IDLE;
            lat_cnt_q <= LC_ZERO;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Pipeline control priority mux: EX redirect > stall > ID redirect.
    always_comb begin
        pc_write_en_o     = 1'b1;
        if_id_write_en_o  = 1'b1;
        if_id_flush_o     = 1'b0;
        id_ex_flush_o     = 1'b0;
        redirect_o        = 1'b0;
        redirect_pc_o     = PC_ZERO;
        id_pred_taken_o   = 1'b0;
        load_use_hazard_o = 1'b0;
        if (rst) begin
            redirect_o = 1'b0;
        end else if (ex_redirect_s) begin
            redirect_o    = 1'b1;
            redirect_pc_o = ex_redirect_pc_s;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (stall_s) begin
            pc_write_en_o     = 1'b0;
            if_id_write_en_o  = 1'b0;
            id_ex_flush_o     = 1'b1;
            load_use_hazard_o = 1'b1;
            id_pred_taken_o   = id_pred_s;
        end else begin
            id_pred_taken_o = id_pred_s;
            if (id_valid_i & id_pred_s) begin
                redirect_o    = 1'b1;
                redirect_pc_o = id_target_i;
                if_id_flush_o = 1'b1;
            end else begin
                redirect_o = 1'b0;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branch_q  <= {CNT_W{1'b0}};
            stat_mispred_q <= {CNT_W{1'b0}};
            stat_stall_q   <= {CNT_W{1'b0}};
        end else begin
            if (ex_valid_i & ex_is_branch_i & (stat_branch_q != CNT_MAX)) begin
                stat_branch_q <= stat_branch_q + CNT_ONE;
            end
            if (ex_redirect_s & (stat_mispred_q != CNT_MAX)) begin
                stat_mispred_q <= stat_mispred_q + CNT_ONE;
            end
            if (stall_s & (stat_stall_q != CNT_MAX)) begin
                stat_stall_q <= stat_stall_q + CNT_ONE;
            end
        end
    end

    assign stat_branch_o  = stat_branch_q;
    assign stat_mispred_o = stat_mispred_q;
    assign stat_stall_o   = stat_stall_q;

endmodule
